// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the set-associative instruction cache.
//   - state_e    : controller states (IDLE lookup, FILL waiting on memory)
//   - DEF_*      : default geometry used by icache_sa and icache_lru_age
//   - log2_f     : ceiling log2 used to derive field widths from the geometry
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int DEF_ADDR_W = 32'sd30;
  localparam int DEF_SETS   = 32'sd4;
  localparam int DEF_WAYS   = 32'sd2;
  localparam int DEF_WORDS  = 32'sd4;
  localparam int DEF_CNT_W  = 32'sd32;

  // Smallest r with 2**r >= value; geometry values are powers of two.
  function automatic int log2_f(input int value);
    int res;
    res = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 32'sd1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_lru_age.sv
// icache_lru_age: true-LRU replacement state, one age per way per set.
//   Age 0 is most recently used, WAYS-1 least recently used; ages of a set
//   always form a permutation of 0..WAYS-1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (age of way w = w)
//   touch_en            make touch_way in touch_set the most recently used
//   touch_set/touch_way set and way being touched
//   query_set           set whose replacement victim is requested
//   inv_mask            invalid ways of query_set (bit w = way w invalid)
//   victim              lowest invalid way, else the way with age WAYS-1
module icache_lru_age
  import icache_pkg::*;
#(
  parameter  int SETS  = DEF_SETS,
  parameter  int WAYS  = DEF_WAYS,
  localparam int IDX_W = log2_f(SETS),
  localparam int AGE_W = log2_f(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [AGE_W-1:0] touch_way,
  input  logic [IDX_W-1:0] query_set,
  input  logic [WAYS-1:0]  inv_mask,
  output logic [AGE_W-1:0] victim
);

  logic [AGE_W-1:0] age_r [SETS][WAYS];
  logic             inv_found_s;
  logic [AGE_W-1:0] inv_way_s;
  logic [AGE_W-1:0] old_way_s;

  // Age update: touched way becomes 0, every younger way ages by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w] <= AGE_W'(w);
        end
      end
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way) begin
          age_r[touch_set][w] <= '0;
        end else if (age_r[touch_set][w] < age_r[touch_set][touch_way]) begin
          age_r[touch_set][w] <= age_r[touch_set][w] + 1'b1;
        end else begin
          age_r[touch_set][w] <= age_r[touch_set][w];
        end
      end
    end
  end

  // Victim selection: an empty way is always preferred over evicting a line.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    old_way_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found_s && inv_mask[w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = AGE_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_r[query_set][w] == AGE_W'(WAYS - 1)) begin
        old_way_s = AGE_W'(w);
      end else begin
        old_way_s = old_way_s;
      end
    end
    if (inv_found_s) begin
      victim = inv_way_s;
    end else begin
      victim = old_way_s;
    end
  end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative read-only instruction cache.
//   Hits are served combinationally in IDLE; a miss latches the line address
//   and victim way, then FILL waits for one line-wide memory response.
// Ports:
//   clk, proc_reset_n             clock, asynchronous active-low reset
//   proc_read, proc_addr          fetch request and word address
//   proc_rdata, proc_stall        fetched word, request not served this cycle
//   flush                         pulse: invalidate every line (fence.i)
//   mem_read, mem_addr            line read request and line address {tag,set}
//   mem_rdata, mem_ready          returned line (word 0 in [31:0]) and its strobe
//   hit_cnt, miss_cnt             wrapping hit / miss counters
module icache_sa
  import icache_pkg::*;
#(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int SETS     = DEF_SETS,
  parameter  int WAYS     = DEF_WAYS,
  parameter  int WORDS    = DEF_WORDS,
  parameter  int CNT_W    = DEF_CNT_W,
  localparam int OFF_W    = log2_f(WORDS),
  localparam int IDX_W    = log2_f(SETS),
  localparam int TAG_W    = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W   = 32 * WORDS,
  localparam int AGE_W    = log2_f(WAYS),
  localparam int LINE_A_W = ADDR_W - OFF_W
) (
  input  logic                clk,
  input  logic                proc_reset_n,
  input  logic                proc_read,
  input  logic [ADDR_W-1:0]   proc_addr,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  input  logic                flush,
  output logic                mem_read,
  output logic [LINE_A_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [WAYS-1:0]     valid_r [SETS];
  logic [TAG_W-1:0]    tag_r   [SETS][WAYS];
  logic [LINE_W-1:0]   data_r  [SETS][WAYS];
  logic [LINE_A_W-1:0] miss_line_r;
  logic [AGE_W-1:0]    victim_r;
  logic                flush_pending_r;

  logic [TAG_W-1:0]    req_tag_s;
  logic [IDX_W-1:0]    req_set_s;
  logic [OFF_W-1:0]    req_off_s;
  logic [IDX_W-1:0]    fill_set_s;
  logic [TAG_W-1:0]    fill_tag_s;
  logic                hit_s;
  logic [AGE_W-1:0]    hit_way_s;
  logic [LINE_W-1:0]   hit_line_s;
  logic                lookup_hit_s;
  logic                miss_s;
  logic                fill_done_s;
  logic                clear_all_s;
  logic [AGE_W-1:0]    victim_s;
  logic                touch_en_s;
  logic [IDX_W-1:0]    touch_set_s;
  logic [AGE_W-1:0]    touch_way_s;

  assign req_off_s  = proc_addr[OFF_W-1:0];
  assign req_set_s  = proc_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag_s  = proc_addr[ADDR_W-1:OFF_W+IDX_W];
  assign fill_set_s = miss_line_r[IDX_W-1:0];
  assign fill_tag_s = miss_line_r[LINE_A_W-1:IDX_W];

  // Tag compare across all ways of the addressed set and word select.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[req_set_s][w] && (tag_r[req_set_s][w] == req_tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = AGE_W'(w);
      end else begin
        hit_s = hit_s;
      end
    end
    hit_line_s = data_r[req_set_s][hit_way_s];
    proc_rdata = hit_line_s[{req_off_s, 5'b00000} +: 32];
  end

  // Controller next state and handshake outputs.
  always_comb begin
    state_nxt_s  = state_r;
    proc_stall   = 1'b0;
    mem_read     = 1'b0;
    mem_addr     = proc_addr[ADDR_W-1:OFF_W];
    lookup_hit_s = 1'b0;
    miss_s       = 1'b0;
    fill_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (proc_read && hit_s) begin
          lookup_hit_s = 1'b1;
        end else if (proc_read) begin
          proc_stall  = 1'b1;
          miss_s      = 1'b1;
          state_nxt_s = FILL;
        end else begin
          proc_stall = 1'b0;
        end
      end
      FILL: begin
        proc_stall = 1'b1;
        mem_addr   = miss_line_r;
        mem_read   = ~mem_ready;
        if (mem_ready) begin
          fill_done_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          fill_done_s = 1'b0;
        end
      end
      default: begin
        proc_stall  = proc_read;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // A flush seen during FILL (now or earlier) also wipes the line being written.
  assign clear_all_s = ((state_r == IDLE) && flush) ||
                       (fill_done_s && (flush || flush_pending_r));

  // Control state, miss latch, flush tracking, valid bits and counters.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_r         <= IDLE;
      miss_line_r     <= '0;
      victim_r        <= '0;
      flush_pending_r <= 1'b0;
      hit_cnt         <= '0;
      miss_cnt        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      if (miss_s) begin
        miss_line_r <= proc_addr[ADDR_W-1:OFF_W];
        victim_r    <= victim_s;
        miss_cnt    <= miss_cnt + 1'b1;
      end
      if (lookup_hit_s) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (fill_done_s) begin
        flush_pending_r <= 1'b0;
      end else if ((state_r == FILL) && flush) begin
        flush_pending_r <= 1'b1;
      end
      if (clear_all_s) begin
        for (int s = 0; s < SETS; s++) begin
          valid_r[s] <= '0;
        end
      end else if (fill_done_s) begin
        valid_r[fill_set_s][victim_r] <= 1'b1;
      end
    end
  end

  // Line storage; tags and data need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_r[fill_set_s][victim_r]  <= fill_tag_s;
      data_r[fill_set_s][victim_r] <= mem_rdata;
    end
  end

  // Hits and fills are mutually exclusive, so one touch port suffices.
  assign touch_en_s  = lookup_hit_s | fill_done_s;
  assign touch_set_s = fill_done_s ? fill_set_s : req_set_s;
  assign touch_way_s = fill_done_s ? victim_r   : hit_way_s;

  icache_lru_age #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk),
    .rst_n     (proc_reset_n),
    .touch_en  (touch_en_s),
    .touch_set (touch_set_s),
    .touch_way (touch_way_s),
    .query_set (req_set_s),
    .inv_mask  (~valid_r[req_set_s]),
    .victim    (victim_s)
  );

endmodule

// File: tb/tb_icache_sa.sv
// Directed testbench for icache_sa: default geometry instance plus a
// 4-way / 8-set / 8-word instance for the replacement-order scenario.
module tb_icache_sa;

  logic         clk = 1'b0;
  logic         proc_reset_n = 1'b1;

  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         flush;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  logic         b_proc_read;
  logic [29:0]  b_proc_addr;
  logic [31:0]  b_proc_rdata;
  logic         b_proc_stall;
  logic         b_flush;
  logic         b_mem_read;
  logic [26:0]  b_mem_addr;
  logic [255:0] b_mem_rdata;
  logic         b_mem_ready;
  logic [31:0]  b_hit_cnt;
  logic [31:0]  b_miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icache_sa u_dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (proc_read),
    .proc_addr    (proc_addr),
    .proc_rdata   (proc_rdata),
    .proc_stall   (proc_stall),
    .flush        (flush),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  icache_sa #(.SETS(8), .WAYS(4), .WORDS(8)) u_big (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (b_proc_read),
    .proc_addr    (b_proc_addr),
    .proc_rdata   (b_proc_rdata),
    .proc_stall   (b_proc_stall),
    .flush        (b_flush),
    .mem_read     (b_mem_read),
    .mem_addr     (b_mem_addr),
    .mem_rdata    (b_mem_rdata),
    .mem_ready    (b_mem_ready),
    .hit_cnt      (b_hit_cnt),
    .miss_cnt     (b_miss_cnt)
  );

  // Memory content: word i of line L is D000_0000 + L*16 + i.
  function automatic logic [31:0] word_f(input logic [31:0] line, input int i);
    return 32'hD000_0000 + (line << 4) + 32'(i);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    proc_read = 1'b0; proc_addr = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    b_proc_read = 1'b0; b_proc_addr = '0; b_flush = 1'b0; b_mem_ready = 1'b0; b_mem_rdata = '0;
    proc_reset_n = 1'b0;
    #2;
    step;
    proc_reset_n = 1'b1;
    step;
  endtask

  // Memory responder for the default instance: waits (bounded) for mem_read,
  // holds off 'delay' cycles, then returns the line for the requested address.
  task automatic serve_fill(input int delay, output logic [27:0] seen, output bit ok);
    ok = 1'b0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (ok) begin
      seen = mem_addr;
      repeat (delay) step;
      for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = word_f({4'h0, seen}, w);
      mem_ready = 1'b1;
      step;
      mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    proc_read = 1'b1; proc_addr = 30'h10; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    b_proc_read = 1'b0; b_proc_addr = '0; b_flush = 1'b0; b_mem_ready = 1'b0; b_mem_rdata = '0;
    #1;
    proc_reset_n = 1'b0;
    #2;
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read: got %b, expected 0", mem_read); end
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b, expected 1", proc_stall); end
    vectors++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_counters: got %0d/%0d, expected 0/0", hit_cnt, miss_cnt); end
    proc_read = 1'b0;
    #1;
    vectors++; if (proc_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_idle: got %b, expected 0", proc_stall); end
    step;
    proc_reset_n = 1'b1;
    step;
  endtask

  task automatic test_cold_miss;
    logic [27:0] seen; bit ok;
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL cold_stall: got %b, expected 1", proc_stall); end
    step;
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 28'h4) begin miscompares++; $display("FAIL cold_mem_req: got %b/%h, expected 1/0000004", mem_read, mem_addr); end
    serve_fill(3, seen, ok);
    vectors++; if (!ok || seen !== 28'h4) begin miscompares++; $display("FAIL cold_fill_addr: got ok=%b addr=%h, expected ok=1 addr=0000004", ok, seen); end
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0040) begin miscompares++; $display("FAIL cold_hit_w0: got %b/%h, expected 0/d0000040", proc_stall, proc_rdata); end
    step;
    proc_addr = 30'h13;
    #1;
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0043) begin miscompares++; $display("FAIL cold_hit_w3: got %b/%h, expected 0/d0000043", proc_stall, proc_rdata); end
    step;
    proc_read = 1'b0;
    #1;
    vectors++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin miscompares++; $display("FAIL cold_counters: got %0d/%0d, expected 2/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_lru;
    logic [27:0] seen; bit ok;
    apply_reset;
    proc_read = 1'b1; proc_addr = 30'h10; step; serve_fill(0, seen, ok);
    proc_addr = 30'h20; step; serve_fill(1, seen, ok);
    vectors++; if (!ok || seen !== 28'h8) begin miscompares++; $display("FAIL lru_fill2: got ok=%b addr=%h, expected ok=1 addr=0000008", ok, seen); end
    proc_addr = 30'h10;
    #1;
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0040) begin miscompares++; $display("FAIL lru_hit10: got %b/%h, expected 0/d0000040", proc_stall, proc_rdata); end
    step;
    proc_addr = 30'h30;
    #1;
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL lru_miss30: got %b, expected 1", proc_stall); end
    step; serve_fill(0, seen, ok);
    vectors++; if (!ok || seen !== 28'hC) begin miscompares++; $display("FAIL lru_fill30: got ok=%b addr=%h, expected ok=1 addr=000000c", ok, seen); end
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_00C0) begin miscompares++; $display("FAIL lru_hit30: got %b/%h, expected 0/d00000c0", proc_stall, proc_rdata); end
    step;
    proc_addr = 30'h11;
    #1;
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0041) begin miscompares++; $display("FAIL lru_kept10: got %b/%h, expected 0/d0000041", proc_stall, proc_rdata); end
    step;
    proc_addr = 30'h20;
    #1;
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL lru_evicted20: got %b, expected 1", proc_stall); end
    step;
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 28'h8) begin miscompares++; $display("FAIL lru_refetch20: got %b/%h, expected 1/0000008", mem_read, mem_addr); end
    serve_fill(0, seen, ok);
    proc_addr = 30'h10;
    #1;
    vectors++; if (proc_stall !== 1'b0) begin miscompares++; $display("FAIL lru_10_survives: got %b, expected 0", proc_stall); end
    proc_read = 1'b0;
  endtask

  task automatic test_idle_flush;
    logic [27:0] seen; bit ok;
    apply_reset;
    proc_read = 1'b1; proc_addr = 30'h10; step; serve_fill(0, seen, ok);
    flush = 1'b1;
    #1;
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0040) begin miscompares++; $display("FAIL flush_same_cycle_hit: got %b/%h, expected 0/d0000040", proc_stall, proc_rdata); end
    step;
    flush = 1'b0;
    #1;
    vectors++; if (proc_stall !== 1'b1 || hit_cnt !== 32'd1) begin miscompares++; $display("FAIL flush_invalidated: got stall=%b hits=%0d, expected 1/1", proc_stall, hit_cnt); end
    step;
    vectors++; if (mem_read !== 1'b1 || miss_cnt !== 32'd2) begin miscompares++; $display("FAIL flush_remiss: got %b/%0d, expected 1/2", mem_read, miss_cnt); end
    serve_fill(0, seen, ok);
    proc_read = 1'b0; flush = 1'b1; step; flush = 1'b0;
    proc_read = 1'b1;
    #1;
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL flush_noread_stall: got %b, expected 1", proc_stall); end
    step;
    vectors++; if (mem_read !== 1'b1 || miss_cnt !== 32'd3) begin miscompares++; $display("FAIL flush_noread_remiss: got %b/%0d, expected 1/3", mem_read, miss_cnt); end
    serve_fill(0, seen, ok);
    proc_read = 1'b0;
  endtask

  task automatic test_flush_in_fill;
    logic [27:0] seen; bit ok;
    apply_reset;
    proc_read = 1'b1; proc_addr = 30'h10; step;
    flush = 1'b1; step; flush = 1'b0; step;
    for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = word_f(32'h4, w);
    mem_ready = 1'b1;
    #1;
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL fillflush_mem_read_drop: got %b, expected 0", mem_read); end
    step;
    mem_ready = 1'b0;
    #1;
    vectors++; if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin miscompares++; $display("FAIL fillflush_line_invalid: got stall=%b mem_read=%b, expected 1/0", proc_stall, mem_read); end
    step;
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 28'h4 || miss_cnt !== 32'd2) begin miscompares++; $display("FAIL fillflush_rerequest: got %b/%h/%0d, expected 1/0000004/2", mem_read, mem_addr, miss_cnt); end
    serve_fill(0, seen, ok);
    vectors++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hD000_0040) begin miscompares++; $display("FAIL fillflush_final_hit: got %b/%h, expected 0/d0000040", proc_stall, proc_rdata); end
    proc_read = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    logic [27:0] seen; bit ok;
    apply_reset;
    proc_read = 1'b1; proc_addr = 30'h10; step;
    vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rstfill_in_fill: got %b, expected 1", mem_read); end
    #2;
    proc_reset_n = 1'b0;
    #1;
    vectors++; if (mem_read !== 1'b0 || miss_cnt !== 32'd0 || hit_cnt !== 32'd0) begin miscompares++; $display("FAIL rstfill_async: got %b/%0d/%0d, expected 0/0/0", mem_read, miss_cnt, hit_cnt); end
    step;
    proc_reset_n = 1'b1;
    #1;
    vectors++; if (proc_stall !== 1'b1) begin miscompares++; $display("FAIL rstfill_remiss: got %b, expected 1", proc_stall); end
    step;
    vectors++; if (mem_read !== 1'b1 || miss_cnt !== 32'd1) begin miscompares++; $display("FAIL rstfill_newfill: got %b/%0d, expected 1/1", mem_read, miss_cnt); end
    serve_fill(0, seen, ok);
    proc_read = 1'b0;
  endtask

  task automatic test_big_geometry;
    bit ok;
    logic [31:0] line;
    apply_reset;
    for (int t = 1; t <= 5; t++) begin
      line = 32'(t * 8 + 3);
      b_proc_addr = 30'(t * 64 + 24);
      b_proc_read = 1'b1;
      #1;
      vectors++; if (b_proc_stall !== 1'b1) begin miscompares++; $display("FAIL big_miss_t%0d: got %b, expected 1", t, b_proc_stall); end
      step;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (b_mem_read) begin ok = 1'b1; break; end
        step;
      end
      vectors++; if (!ok || b_mem_addr !== line[26:0]) begin miscompares++; $display("FAIL big_fill_t%0d: got ok=%b addr=%h, expected ok=1 addr=%h", t, ok, b_mem_addr, line[26:0]); end
      for (int w = 0; w < 8; w++) b_mem_rdata[w*32 +: 32] = word_f(line, w);
      b_mem_ready = 1'b1;
      step;
      b_mem_ready = 1'b0;
    end
    for (int t = 2; t <= 5; t++) begin
      line = 32'(t * 8 + 3);
      b_proc_addr = 30'(t * 64 + 24 + 5);
      #1;
      vectors++; if (b_proc_stall !== 1'b0 || b_proc_rdata !== word_f(line, 5)) begin miscompares++; $display("FAIL big_hit_t%0d: got %b/%h, expected 0/%h", t, b_proc_stall, b_proc_rdata, word_f(line, 5)); end
    end
    b_proc_addr = 30'(64 + 24);
    #1;
    vectors++; if (b_proc_stall !== 1'b1) begin miscompares++; $display("FAIL big_evicted_t1: got %b, expected 1", b_proc_stall); end
    b_proc_read = 1'b0;
    #1;
    vectors++; if (b_miss_cnt !== 32'd5 || b_hit_cnt !== 32'd0) begin miscompares++; $display("FAIL big_counters: got %0d/%0d, expected 5/0", b_miss_cnt, b_hit_cnt); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_lru;
    test_idle_flush;
    test_flush_in_fill;
    test_reset_mid_fill;
    test_big_geometry;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
